// File: rtl/mult32_seq_pkg.sv
// mult32_seq_pkg: state encodings and step count shared by the sequential multiplier
package mult32_seq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic [4:0] LAST_STEP = 5'd31;
endpackage

// File: rtl/mult32_seq_if.sv
// mult32_seq_if: start/busy/done handshake plus operand and product buses
interface mult32_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] p;
    modport master (output start, a, b, input busy, done, p);
    modport slave (input start, a, b, output busy, done, p);
endinterface

// File: rtl/adder32b.sv
// adder32b: 32-bit adder with carry-in and carry-out
module adder32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        c
);
    assign {c, s} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

// File: rtl/mult32_seq.sv
// mult32_seq: unsigned 32x32->64 shift-and-add multiplier, one multiplier bit per clock
module mult32_seq
    import mult32_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mult32_seq_if.slave  bus
);
    state_t      state, state_n;
    logic [31:0] mcand, mcand_n;
    logic [63:0] prod, prod_n;
    logic [4:0]  count, count_n;
    logic [31:0] sum;
    logic        carry;

    adder32b u_add (
        .a   (prod[63:32]),
        .b   (mcand),
        .cin (1'b0),
        .s   (sum),
        .c   (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            prod  <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            mcand <= mcand_n;
            prod  <= prod_n;
            count <= count_n;
        end
    end

    // The adder carry lands in bit 63 as the accumulator shifts right, so nothing is lost
    always_comb begin
        state_n = state;
        mcand_n = mcand;
        prod_n  = prod;
        count_n = count;
        case (state)
            IDLE: if (bus.start) begin
                state_n = CALC;
                mcand_n = bus.a;
                prod_n  = {32'b0, bus.b};
                count_n = '0;
            end
            CALC: begin
                prod_n  = prod[0] ? {carry, sum, prod[31:1]} : {1'b0, prod[63:32], prod[31:1]};
                count_n = count + 5'd1;
                state_n = (count == LAST_STEP) ? DONE : CALC;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.p    = prod;
endmodule

// File: doc/mult32_seq.md
Name: mult32_seq

Overview:
Sequential unsigned 32x32 -> 64-bit shift-and-add multiplier for the ALU/datapath.
- Holds a 64-bit product register.
- Each add step goes through one adder32b instance, which forms hi + multiplicand plus carry-out.
- One multiplier bit is retired per clock.
- start/busy/done handshake toward the issuing control unit.

Parameters:
none (operand width fixed at 32, matching adder32b; iteration count fixed at 32)

Ports:
clk    input   1   single clock, rising edge
rst    input   1   reset, synchronous, active-high
start  input   1   request; sampled only in IDLE
a      input   32  multiplicand, captured on accepted start
b      input   32  multiplier, captured on accepted start
busy   output  1   high whenever state != IDLE
done   output  1   one-cycle pulse; p valid
p      output  64  product; driven directly from the product register

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- rst=1 at a rising edge forces state=IDLE, prod=0, mcand=0, count=0, busy=0, done=0, p=0.
- Reset overrides everything, including mid-CALC; the partial result is discarded.
- Registers:
  - mcand[31:0]
  - prod[63:0]: upper half is the accumulator hi, lower half is the multiplier
  - count[4:0]
  - state
- States: IDLE, CALC, DONE.
- IDLE: if start=1 at an edge, load mcand=a, prod={32'b0,b}, count=0, go to CALC. Otherwise hold all registers; p keeps the last result.
- CALC, each edge performs one step:
  - adder32b computes {c,s} = hi + mcand, cin=0.
  - If prod[0]=1: prod <= {c, s, prod[31:1]}.
  - Else: prod <= {1'b0, hi, prod[31:1]}.
  - count <= count+1.
  - When the step executes with count==31, go to DONE.
- DONE: done=1 for exactly this cycle, busy=1, then IDLE at the next edge.
- Timing: if start is sampled in cycle n, CALC occupies cycles n+1..n+32, done=1 in cycle n+33, IDLE in n+34.
  - Fixed latency of 33 cycles, independent of operand values.
- start while busy (CALC or DONE) is ignored. No queuing; a and b changes are ignored.
- Back-to-back: earliest next accept is cycle n+34; done never stays high two cycles.
- p mirrors prod, so it changes during CALC. The consumer samples p on done; p remains stable afterwards until the next accepted start.
- Width rules:
  - The adder carry-out enters bit 63 on the shift, so no overflow is possible.
  - The product is exact unsigned modulo 2^64. There is no signed mode.
- done and busy are registered state decodes (glitch-free, no combinational path from start).

Decomposition:
- Shared constants: state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and LAST_STEP=5'd31, in the project-wide defines/localparam file.
- Sub-module: adder32b, reused unchanged as the datapath adder (cin tied 0).
- FSM and shift logic stay inline; no further split.

Test Plan:
- a=3, b=5, start in cycle 0 -> busy cycles 1-33; done=1 only in cycle 33; p=64'h0000_0000_0000_000F.
- a=b=32'hFFFF_FFFF -> p=64'hFFFF_FFFE_0000_0001 at done (checks carry into bit 63 every step).
- a=2, b=32'h8000_0000 -> p=64'h0000_0001_0000_0000; a=0, b=32'h1234_5678 -> p=0; both with latency 33.
- Start pulsed again in cycles 5 and 33 with new operands -> both ignored; the first product is unaffected; a start in cycle 34 is accepted.
- rst=1 in cycle 10 of an operation -> next cycle busy=0, done=0, p=0; no done pulse follows; a new start multiplies correctly.
- Randomized 1000 operand pairs vs a 64-bit reference model, with random idle gaps between starts -> exact match and 33-cycle latency every time.
